// File: rtl/ps2_pkg.sv
`default_nettype none
// ps2_pkg -- shared PS/2 definitions for the host transmitter and keyboard receiver.
// Rev 1.0
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ps2_sync_edge -- pad synchronisers for PS/2 clock/data plus clock falling-edge detect.
// Rev 1.0
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_ff;
  logic [SYNC_STAGES-1:0] data_ff;
  logic                   clk_prev;

  // Idle bus level is high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[SYNC_STAGES-2:0], ps2_clk};
      data_ff  <= {data_ff[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_ff[SYNC_STAGES-1];
    end
  end

  assign clk_sync  = clk_ff[SYNC_STAGES-1];
  assign data_sync = data_ff[SYNC_STAGES-1];
  assign clk_fall  = clk_prev & ~clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ps2_host_tx -- PS/2 host-to-device transmitter: RTS handshake, frame shift-out, ACK sample.
// Rev 1.0
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = $clog2(PS2_FRAME_BITS);

  // The RTS cycle is the last of the INHIBIT_CYCLES clock-low cycles, so INHIBIT itself is one shorter.
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] STOP_IDX = BW'(PS2_FRAME_BITS - 2);

  ps2_state_t    state, state_nxt;
  logic [9:0]    shreg, shreg_nxt;
  logic [BW-1:0] bitcnt, bitcnt_nxt;
  logic [IW-1:0] inh_cnt, inh_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          ack_smp, ack_smp_nxt;
  logic          clk_oe_nxt, data_oe_nxt;
  logic          done_nxt, ack_ok_nxt, err_nxt;

  logic clk_sync, data_sync, clk_fall;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign tx_ready = (state == IDLE) && !done;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ack_smp     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bitcnt      <= bitcnt_nxt;
      inh_cnt     <= inh_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      ack_smp     <= ack_smp_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      done        <= done_nxt;
      ack_ok      <= ack_ok_nxt;
      err_timeout <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bitcnt_nxt  = bitcnt;
    inh_cnt_nxt = inh_cnt;
    to_cnt_nxt  = to_cnt;
    ack_smp_nxt = ack_smp;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    ack_ok_nxt  = ack_ok;
    err_nxt     = err_timeout;

    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx_valid && tx_ready) begin
          state_nxt   = INHIBIT;
          shreg_nxt   = {1'b1, odd_parity(tx_data), tx_data};
          bitcnt_nxt  = '0;
          inh_cnt_nxt = '0;
          clk_oe_nxt  = 1'b1;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_nxt   = RTS;
          data_oe_nxt = 1'b1;
        end else begin
          inh_cnt_nxt = inh_cnt + 1'b1;
        end
      end
      RTS: begin
        state_nxt  = SEND;
        clk_oe_nxt = 1'b0;
        to_cnt_nxt = '0;
      end
      SEND: begin
        if (clk_fall) begin
          data_oe_nxt = ~shreg[0];
          shreg_nxt   = {1'b0, shreg[9:1]};
          bitcnt_nxt  = bitcnt + 1'b1;
          to_cnt_nxt  = '0;
          if (bitcnt == STOP_IDX) state_nxt = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_smp_nxt = ~data_sync;
          to_cnt_nxt  = '0;
          state_nxt   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_fall) begin
          to_cnt_nxt = '0;
        end else if (clk_sync && data_sync) begin
          state_nxt  = IDLE;
          done_nxt   = 1'b1;
          ack_ok_nxt = ack_smp;
          err_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A silent device aborts the frame from any device-clocked state; this overrides a normal finish.
    if ((state == SEND || state == ACK || state == WAIT_IDLE) && !clk_fall) begin
      if (to_cnt == TMO_LAST) begin
        state_nxt   = IDLE;
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        done_nxt    = 1'b1;
        ack_ok_nxt  = 1'b0;
        err_nxt     = 1'b1;
      end else begin
        to_cnt_nxt = to_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ps2_host_tx -- directed bench with an open-drain device model clocking at a 40-cycle period.
// Rev 1.0
module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout;
  logic       bfm_clk_low  = 1'b0;
  logic       bfm_data_low = 1'b0;

  wire ps2_clk  = ~(ps2_clk_oe | bfm_clk_low);
  wire ps2_data = ~(ps2_data_oe | bfm_data_low);

  int n_checks = 0;
  int n_fail   = 0;

  int   done_cnt    = 0;
  logic prev_done   = 1'b0;
  logic d_ack       = 1'b0;
  logic d_err       = 1'b0;
  logic d_clk_oe    = 1'b0;
  logic d_data_oe   = 1'b0;
  logic d_busy      = 1'b0;
  logic d_ready     = 1'b0;
  logic ready_after = 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err_timeout (err_timeout)
  );

  // Capture the done pulse and the cycle after it, wherever the stimulus happens to be.
  always @(negedge clk) begin
    prev_done <= done;
    if (prev_done) ready_after <= tx_ready;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      d_ack     <= ack_ok;
      d_err     <= err_timeout;
      d_clk_oe  <= ps2_clk_oe;
      d_data_oe <= ps2_data_oe;
      d_busy    <= busy;
      d_ready   <= tx_ready;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One host transfer; the device gives nclk clocks and ACKs at the 11th if dev_ack.
  task automatic xfer(input string nm, input logic [7:0] b, input logic par,
                      input int nclk, input logic dev_ack, input logic poke);
    logic [9:0] bits;
    int hi, rts_at, w, c0, lat;
    bits = '0; hi = 0; rts_at = -1; w = 0;
    check_eq({nm, ":ready"}, tx_ready, 1);
    c0 = done_cnt;
    tx_data = b; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    while (ps2_clk_oe && hi < 4*INH) begin
      if (ps2_data_oe && rts_at < 0) rts_at = hi;
      hi++;
      tick(1);
    end
    check_eq({nm, ":inhibit_len"}, hi, INH);
    check_eq({nm, ":rts_pos"}, rts_at, INH-1);
    check_eq({nm, ":start_bit"}, ps2_data, 0);
    check_eq({nm, ":busy"}, busy, 1);
    tick(6);
    if (poke) begin
      tx_data = 8'h55; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    end
    for (int k = 1; k <= nclk; k++) begin
      bfm_clk_low = 1'b1; tick(HALF-1);
      if (k <= 10) bits[k-1] = ps2_data;
      tick(1);
      bfm_clk_low = 1'b0; tick(HALF/2);
      if (k == 10) bfm_data_low = dev_ack;
      tick(HALF - HALF/2);
    end
    bfm_data_low = 1'b0;
    while (done_cnt == c0 && w < TMO+100) begin
      tick(1);
      w++;
    end
    check_eq({nm, ":done"}, done_cnt - c0, 1);
    tick(1);
    check_eq({nm, ":ack_ok"}, d_ack, (nclk >= 11) && dev_ack);
    check_eq({nm, ":err_timeout"}, d_err, nclk < 11);
    check_eq({nm, ":oe_at_done"}, {d_clk_oe, d_data_oe}, 2'b00);
    check_eq({nm, ":busy_at_done"}, d_busy, 0);
    check_eq({nm, ":ready_at_done"}, d_ready, 0);
    check_eq({nm, ":ready_after_done"}, ready_after, 1);
    if (nclk >= 10) begin
      check_eq({nm, ":frame"}, bits, {1'b1, par, b});
    end else begin
      check_eq({nm, ":partial_bits"}, bits[2:0], b[2:0]);
      lat = w + 2*HALF;
      check_eq({nm, ":tmo_latency_ok"}, (lat >= TMO) && (lat <= TMO+8), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    resetn = 1'b0;
    tick(3);
    check_eq("reset:tx_ready", tx_ready, 1);
    check_eq("reset:busy", busy, 0);
    check_eq("reset:oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check_eq("reset:done", done, 0);
    check_eq("reset:ack_ok", ack_ok, 0);
    check_eq("reset:err_timeout", err_timeout, 0);
    resetn = 1'b1;
    tick(2);

    // Parity column hand-computed: odd parity over the data byte.
    xfer("ed",   8'hED, 1'b1, 11, 1'b1, 1'b0);
    xfer("01",   8'h01, 1'b0, 11, 1'b1, 1'b0);
    xfer("00",   8'h00, 1'b1, 11, 1'b1, 1'b0);
    xfer("nack", 8'hED, 1'b1, 11, 1'b0, 1'b0);
    xfer("tmo",  8'h00, 1'b1, 3,  1'b0, 1'b0);

    c0 = done_cnt;
    xfer("poke", 8'h02, 1'b0, 11, 1'b1, 1'b1);
    tick(20);
    check_eq("poke:no_queue_busy", busy, 0);
    check_eq("poke:no_queue_clk_oe", ps2_clk_oe, 0);
    check_eq("poke:single_done", done_cnt - c0, 1);

    xfer("b2b_ed", 8'hED, 1'b1, 11, 1'b1, 1'b0);
    xfer("b2b_02", 8'h02, 1'b0, 11, 1'b1, 1'b0);

    // Reset in the middle of SEND while the host is driving a zero data bit.
    tx_data = 8'h00; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    tick(INH + 4);
    bfm_clk_low = 1'b1; tick(HALF);
    bfm_clk_low = 1'b0; tick(HALF);
    bfm_clk_low = 1'b1; tick(6);
    check_eq("rst:pre_busy", busy, 1);
    check_eq("rst:pre_data_oe", ps2_data_oe, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst:clk_oe", ps2_clk_oe, 0);
    check_eq("rst:data_oe", ps2_data_oe, 0);
    bfm_clk_low = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
    check_eq("rst:tx_ready", tx_ready, 1);
    check_eq("rst:busy", busy, 0);
    xfer("post_rst", 8'hED, 1'b1, 11, 1'b1, 1'b0);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
